// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one multi-cycle divider core among NREQ requesters.
// Resolves divide-by-zero locally and aborts a hung divide with a watchdog.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for any req_valid; grants winner and captures operands
// ISSUE  | one cycle; pulses div_start, or short-circuits a zero divisor
// WAIT   | core busy; waits for div_done or watchdog expiry
// RESP   | holds the registered response until rsp_ready
module divider_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*2*WIDTH-1:0]   req_dividend,
  input  logic [NREQ*WIDTH-1:0]     req_divisor,
  output logic                      div_start,
  output logic [2*WIDTH-1:0]        div_dividend,
  output logic [WIDTH-1:0]          div_divisor,
  input  logic                      div_done,
  input  logic [2*WIDTH-1:0]        div_quotient,
  input  logic [WIDTH-1:0]          div_remainder,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [2*WIDTH-1:0]        rsp_quotient,
  output logic [WIDTH-1:0]          rsp_remainder,
  output logic                      rsp_dbz,
  output logic                      rsp_err
);

  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant;
  logic [WDW-1:0] wdog;
  logic           any_valid;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] idx;
  logic           divisor_zero;

  // Rotating priority search beginning just after the last accepted requester.
  always_comb begin
    any_valid = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(last_grant) + 1 + i) % NREQ);
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && !rst && any_valid) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign divisor_zero = (div_divisor == '0);
  assign div_start    = (state == S_ISSUE) && !divisor_zero;
  assign rsp_valid    = (state == S_RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_valid) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = divisor_zero ? S_RESP : S_WAIT;
      S_WAIT:  if (div_done || wdog == WD_LAST) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      last_grant    <= IDW'(NREQ - 1);
      wdog          <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dbz       <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            last_grant   <= win_id;
            rsp_id       <= win_id;
            div_dividend <= req_dividend[win_id*2*WIDTH +: 2*WIDTH];
            div_divisor  <= req_divisor[win_id*WIDTH +: WIDTH];
          end
        end
        S_ISSUE: begin
          wdog <= '0;
          if (divisor_zero) begin
            rsp_quotient  <= '1;
            rsp_remainder <= div_dividend[WIDTH-1:0];
            rsp_dbz       <= 1'b1;
            rsp_err       <= 1'b0;
          end
        end
        S_WAIT: begin
          // A completion in the same cycle as expiry still counts as success.
          if (div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_dbz       <= 1'b0;
            rsp_err       <= 1'b0;
          end else if (wdog == WD_LAST) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
            rsp_err       <= 1'b1;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Round-robin scheduler that shares one multi-cycle sequential divider core among NREQ requesters. It accepts one request at a time over per-requester valid/ready handshakes, launches the divider with a single-cycle start pulse, and waits for completion. It returns the quotient and remainder tagged with the requester index. Divide-by-zero is resolved locally without starting the core, and a watchdog aborts a hung divide.

## Interface
- WIDTH, 4: divisor width; dividend and quotient are 2*WIDTH bits.
- NREQ, 4: number of requesters (2..16); IDW = clog2(NREQ).
- TIMEOUT, 64: maximum WAIT cycles before abort (≥2).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  one-hot grant/accept.
- req_dividend  in  NREQ*2*WIDTH  packed; requester i at [i*2W +: 2W].
- req_divisor  in  NREQ*WIDTH  packed; requester i at [i*W +: W].
- div_start  out  1  one-cycle launch pulse to the core.
- div_dividend  out  2*WIDTH  operand to the core; held ISSUE..WAIT.
- div_divisor  out  WIDTH  operand to the core; held ISSUE..WAIT.
- div_done  in  1  core completion strobe.
- div_quotient  in  2*WIDTH  core quotient, valid with div_done.
- div_remainder  in  WIDTH  core remainder, valid with div_done.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  IDW  index of the requester served.
- rsp_quotient  out  2*WIDTH  result quotient.
- rsp_remainder  out  WIDTH  result remainder.
- rsp_dbz  out  1  divisor was zero.
- rsp_err  out  1  watchdog abort.

## Operation
- FSM states:
  - IDLE: if any req_valid, grant a winner and capture its operands, then go to ISSUE; otherwise stay in IDLE.
  - ISSUE: if the captured divisor is 0, go to RESP with dbz; otherwise pulse div_start and go to WAIT.
  - WAIT: on div_done, capture results and go to RESP; on watchdog expiry, go to RESP with err.
  - RESP: hold rsp_valid until rsp_ready, then go to IDLE.
- Arbitration:
  - Search starts at last_grant+1 modulo NREQ and grants the first valid requester.
  - last_grant resets to NREQ-1, so requester 0 wins first after reset.
  - last_grant updates only on accept.
- req_ready is nonzero only in IDLE, is combinational from req_valid and last_grant, and is exactly one-hot on the winner.
- Requesters whose valid deasserts before grant are simply skipped; no request is dropped once accepted.
- Divide-by-zero response: quotient = all ones; remainder = dividend[WIDTH-1:0]; dbz=1, err=0. div_start is never asserted.
- Watchdog: a counter clears on entry to WAIT and increments each WAIT cycle without div_done. When it reaches TIMEOUT-1, the block goes to RESP with quotient=0, remainder=0, err=1.
- div_done handling:
  - Sampled only in WAIT; ignored in IDLE, ISSUE and RESP, including stale done pulses after reset or abort.
  - div_done and watchdog expiry in the same cycle: done wins, err=0.
- rsp_* fields are registered and stable while rsp_valid=1 && rsp_ready=0.

## Timing
- Reset values: req_ready=0 (combinational, forced 0 in reset), div_start=0, div_dividend=0, div_divisor=0, rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_remainder=0, rsp_dbz=0, rsp_err=0; state=IDLE, last_grant=NREQ-1, watchdog=0.
- Reset mid-operation: the in-flight request is discarded with no response.
- Cycle numbering:
  - Accept at edge k (IDLE, valid&ready).
  - ISSUE occupies cycle k+1, with div_start=1 for exactly that cycle.
  - WAIT begins at cycle k+2.
  - div_done seen in cycle m gives rsp_valid=1 from cycle m+1.
- Divide-by-zero: rsp_valid=1 from cycle k+2.
- Minimum occupancy is 4 cycles per operation (IDLE, ISSUE, 1 WAIT, 1 RESP with rsp_ready=1).
- The next grant can occur in the cycle after the RESP handshake.
- Only one operation is outstanding at a time.

## Test plan
- Single request: req 2 issues dividend 100, divisor 7.
  - div_start at k+1 with div_dividend=100, div_divisor=7.
  - Model returns done 3 cycles later → rsp id=2, q=14, r=2, dbz=0, err=0.
- Contention: all 4 valid with distinct operands (200/9, 50/5, 17/3, 255/15), valid held high.
  - Grants are in order 0,1,2,3.
  - Responses: q/r = 22/2, 10/0, 5/2, 17/0.
  - After that, re-asserted req 1 alone is granted next.
- Divide-by-zero: req 3 issues dividend 0x5A, divisor 0.
  - rsp at k+2 with q=0xFF, r=0xA, dbz=1.
  - div_start never asserted.
- Backpressure: rsp_ready held low 5 cycles with req 0,1 valid.
  - rsp fields stay constant and req_ready=0 throughout.
  - After the handshake, req 1 is granted.
- Watchdog with TIMEOUT=8: model never asserts done.
  - rsp_err=1, q=0, r=0 after 8 WAIT cycles.
  - A late div_done in IDLE is ignored; the next request completes normally.
- Reset in WAIT: assert rst for 1 cycle.
  - All outputs read their reset values and no response appears.
  - The next grant goes to requester 0.
